// File: rtl/ram_arbiter_if.sv
// Request/response bus between one master (core LSU or debug loader) and ram_arbiter.
// master drives the request fields; slave (the arbiter) drives grant and response.
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, size, is_unsigned, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, is_unsigned, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-master arbiter/sequencer for a 4 x 8-bit byte-lane RAM with 1-cycle sync read.
// Optional RAM_ARB_ADDR_CHK_EN: reject accesses with nonzero byte-address bits above ADDR_HI.
module ram_arbiter #(
  parameter int unsigned AW      = 12,
  parameter int unsigned ADDR_HI = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave m0,
  ram_arbiter_if.slave m1,
  output logic [3:0]   ram_wen,
  output logic [31:0]  ram_w_addr,
  output logic [31:0]  ram_w_data,
  output logic         ram_ren,
  output logic [31:0]  ram_r_addr,
  input  logic [31:0]  ram_r_data
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RSP  = 1'b1;
  localparam int unsigned PAD_W = 31 - ADDR_HI;

  logic [0:0] state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       rsp_owner_q, rsp_we_q, rsp_uns_q, rsp_err_q;
  logic [1:0] rsp_off_q, rsp_size_q;

  logic        grant, sel;
  logic        s_we, s_uns, s_err, addr_oob;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, fwd_addr, rep_data;
  logic [3:0]  size_mask;

  // sel: 0 = M0, 1 = M1. Contention goes to rr_ptr; a lone requester wins outright.
  always_comb begin
    grant = rst & (m0.req | m1.req);
    if (m0.req && m1.req) begin
      sel = rr_ptr_q;
    end else begin
      sel = m1.req;
    end
  end

  assign m0.gnt = grant & ~sel;
  assign m1.gnt = grant & sel;

  always_comb begin
    s_we    = sel ? m1.we          : m0.we;
    s_uns   = sel ? m1.is_unsigned : m0.is_unsigned;
    s_size  = sel ? m1.size        : m0.size;
    s_addr  = sel ? m1.addr        : m0.addr;
    s_wdata = sel ? m1.wdata       : m0.wdata;
  end

`ifdef RAM_ARB_ADDR_CHK_EN
  assign addr_oob = |s_addr[31:ADDR_HI+1];
`else
  // Upper bits ignored: the RAM aliases every 2^(ADDR_HI+1) bytes.
  assign addr_oob = 1'b0;
  logic unused_addr_hi;
  assign unused_addr_hi = ^s_addr[31:ADDR_HI+1];
`endif

  always_comb begin
    size_mask = 4'b0000;
    rep_data  = '0;
    s_err     = 1'b0;
    case (s_size)
      2'd0: begin
        size_mask = 4'b0001;
        rep_data  = {4{s_wdata[7:0]}};
      end
      2'd1: begin
        size_mask = 4'b0011;
        rep_data  = {2{s_wdata[15:0]}};
        s_err     = s_addr[0];
      end
      2'd2: begin
        size_mask = 4'b1111;
        rep_data  = s_wdata;
        s_err     = |s_addr[1:0];
      end
      default: s_err = 1'b1;
    endcase
    s_err = s_err | addr_oob;
  end

  assign fwd_addr = {{PAD_W{1'b0}}, s_addr[ADDR_HI:0]};

  always_comb begin
    ram_wen    = 4'b0000;
    ram_w_addr = '0;
    ram_w_data = '0;
    ram_ren    = 1'b0;
    ram_r_addr = '0;
    if (grant && !s_err) begin
      if (s_we) begin
        ram_wen    = size_mask << s_addr[1:0];
        ram_w_addr = fwd_addr;
        ram_w_data = rep_data;
      end else begin
        ram_ren    = 1'b1;
        ram_r_addr = fwd_addr;
      end
    end
  end

  always_comb begin
    state_d  = grant ? RSP : IDLE;
    rr_ptr_d = (grant && m0.req && m1.req) ? ~rr_ptr_q : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_uns_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_off_q   <= 2'd0;
      rsp_size_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        rsp_owner_q <= sel;
        rsp_we_q    <= s_we;
        rsp_uns_q   <= s_uns;
        rsp_err_q   <= s_err;
        rsp_off_q   <= s_addr[1:0];
        rsp_size_q  <= s_size;
      end
    end
  end

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  // Lane select and extension use the offset/size captured at grant time.
  always_comb begin
    case (rsp_off_q)
      2'd0:    lane_b = ram_r_data[7:0];
      2'd1:    lane_b = ram_r_data[15:8];
      2'd2:    lane_b = ram_r_data[23:16];
      default: lane_b = ram_r_data[31:24];
    endcase
    lane_h = rsp_off_q[1] ? ram_r_data[31:16] : ram_r_data[15:0];
    case (rsp_size_q)
      2'd0:    ld_data = rsp_uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    ld_data = rsp_uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_data = ram_r_data;
    endcase
    if (rsp_we_q || rsp_err_q) begin
      ld_data = '0;
    end
  end

  assign m0.rvalid = (state_q == RSP) & ~rsp_owner_q;
  assign m1.rvalid = (state_q == RSP) & rsp_owner_q;
  assign m0.err    = m0.rvalid & rsp_err_q;
  assign m1.err    = m1.rvalid & rsp_err_q;
  assign m0.rdata  = m0.rvalid ? ld_data : '0;
  assign m1.rdata  = m1.rvalid ? ld_data : '0;

endmodule
